// File: rtl/in_buffer_writer.sv
// Writes one frame of N streamed samples into the FFT input buffer and pulses done_o when it is full.
// Define BIT_REVERSE_EN to store the frame in bit-reversed address order; otherwise natural order.
module in_buffer_writer #(
    parameter int N      = 16,
    parameter int SIZE   = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] din,
    output logic              ready_o,
    output logic              en_wr,
    output logic [SIZE-1:0]   wr_ptr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done_o,
    output logic              ovf_o
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    localparam logic [SIZE:0] N_CNT = (SIZE+1)'(N);

    state_t        state;
    logic [SIZE:0] cnt;
    logic          accept;

    function automatic logic [SIZE-1:0] map_addr(input logic [SIZE:0] k);
        logic [SIZE-1:0] a;
`ifdef BIT_REVERSE_EN
        for (int i = 0; i < SIZE; i++) begin
            a[i] = k[SIZE-1-i];
        end
`else
        a = k[SIZE-1:0];
`endif
        return a;
    endfunction

    // ready depends only on registered state so the upstream path stays short
    assign ready_o = (state == WAIT) || ((state == WRITE) && (cnt < N_CNT));
    assign accept  = ready_o && valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            en_wr   <= 1'b0;
            wr_ptr  <= '0;
            wr_data <= '0;
            done_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            en_wr  <= 1'b0;
            done_o <= 1'b0;
            if (accept) begin
                state   <= WRITE;
                cnt     <= cnt + 1'b1;
                en_wr   <= 1'b1;
                wr_ptr  <= map_addr(cnt);
                wr_data <= din;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                    WAIT: state <= WAIT;
                    WRITE: begin
                        if (cnt == N_CNT) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            // start in IDLE wins over a simultaneous sample, which is dropped silently
            if ((state == IDLE) && start_i) begin
                ovf_o <= 1'b0;
            end else if (valid_i && !ready_o) begin
                ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_in_buffer_writer.sv
// Bench for in_buffer_writer: frame-level model (active flag, sample count) checked every cycle.
// Compile with the same BIT_REVERSE_EN setting as the RTL.
module tb_in_buffer_writer;

    localparam int N = 16, SIZE = 4, DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0, start_i = 1'b0, valid_i = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              ready_o, en_wr, done_o, ovf_o;
    logic [SIZE-1:0]   wr_ptr;
    logic [DATA_W-1:0] wr_data;

    in_buffer_writer #(.N(N), .SIZE(SIZE), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i), .din(din),
        .ready_o(ready_o), .en_wr(en_wr), .wr_ptr(wr_ptr), .wr_data(wr_data),
        .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;

    // reference model: a frame is "active" from accepted start until N samples are in
    bit          m_active, m_done, m_en, m_ovf;
    int          m_taken;
    logic [SIZE-1:0]   m_ptr;
    logic [DATA_W-1:0] m_data;

    function automatic logic [SIZE-1:0] ref_map(input int k);
        logic [SIZE-1:0] r;
        r = '0;
`ifdef BIT_REVERSE_EN
        for (int b = 0; b < SIZE; b++) if ((k >> b) & 1) r[SIZE-1-b] = 1'b1;
`else
        r = SIZE'(k);
`endif
        return r;
    endfunction

    function automatic logic [DATA_W+SIZE+3:0] exp_vec();
        return {(m_active && m_taken < N), m_en, m_ptr, m_data, m_done, m_ovf};
    endfunction

    wire [DATA_W+SIZE+3:0] obs = {ready_o, en_wr, wr_ptr, wr_data, done_o, ovf_o};

    task automatic step(input logic r, input logic s, input logic v, input logic [DATA_W-1:0] d);
        bit rdy, idle, acc, nd;
        rst = r; start_i = s; valid_i = v; din = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_active = 0; m_done = 0; m_en = 0; m_ovf = 0; m_taken = 0; m_ptr = '0; m_data = '0;
        end else begin
            rdy  = m_active && m_taken < N;
            idle = !m_active && !m_done;
            acc  = rdy && v;
            nd   = m_active && m_taken == N;
            if (idle && s) m_ovf = 0;
            else if (v && !rdy) m_ovf = 1;
            m_en = acc;
            if (acc) begin
                m_ptr = ref_map(m_taken); m_data = d; m_taken++;
            end
            m_done = nd;
            if (nd) m_active = 0;
            if (idle && s) begin
                m_active = 1; m_taken = 0;
            end
        end
        #1;
        rst = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 16'h0);
        step(1, 1, 1, 16'hBEEF);
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_state got %h expected 0", obs);
        end
    endtask

    task automatic test_back_to_back();
        int strobes = 0, dones = 0, last_strobe = -1, done_cyc = -1;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < N + 4; i++) begin
            step(0, 0, i < N, DATA_W'(i));
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b cyc %0d got %h expected %h", i, obs, exp_vec());
            end
            if (en_wr) begin
                vectors++;
                if (wr_ptr !== ref_map(strobes) || wr_data !== DATA_W'(strobes)) begin
                    miscompares++;
                    $display("FAIL b2b_addr strobe %0d got %0d/%0d expected %0d/%0d",
                             strobes, wr_ptr, wr_data, ref_map(strobes), strobes);
                end
                strobes++; last_strobe = i;
            end
            if (done_o) begin dones++; done_cyc = i; end
        end
        vectors++;
        if (strobes != N || dones != 1 || done_cyc != last_strobe + 1 || last_strobe != N - 1) begin
            miscompares++;
            $display("FAIL b2b_frame strobes %0d dones %0d last %0d done_at %0d expected 16/1/15/16",
                     strobes, dones, last_strobe, done_cyc);
        end
    endtask

    task automatic test_toggle();
        int strobes = 0, dones = 0;
        logic [DATA_W-1:0] q[$];
        step(0, 1, 0, 0);
        for (int i = 0; i < 4 * N && dones == 0; i++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom);
            if (i % 2 == 0 && q.size() < N) q.push_back(d);
            step(0, 0, i % 2 == 0, d);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL toggle cyc %0d got %h expected %h", i, obs, exp_vec());
            end
            if (en_wr) begin
                vectors++;
                if (wr_data !== q[strobes]) begin
                    miscompares++;
                    $display("FAIL toggle_data strobe %0d got %h expected %h", strobes, wr_data, q[strobes]);
                end
                strobes++;
            end
            if (done_o) dones++;
        end
        step(0, 0, 0, 0);
        vectors++;
        if (strobes != N || dones != 1 || ovf_o !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_frame strobes %0d dones %0d ovf %b expected 16/1/0", strobes, dones, ovf_o);
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 1, 16'h1111);
        vectors++;
        if (ovf_o !== 1'b1 || en_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_idle got ovf %b en %b expected 1 0", ovf_o, en_wr);
        end
        step(0, 1, 0, 0);
        vectors++;
        if (ovf_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_on_start got %b expected 0", ovf_o);
        end
        for (int i = 0; i < N + 1; i++) step(0, 0, 1, DATA_W'(100 + i));
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs !== exp_vec() || ovf_o !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_hold cyc %0d got %h expected %h", i, obs, exp_vec());
            end
            step(0, 0, 0, 0);
        end
        step(0, 1, 0, 0);
        vectors++;
        if (ovf_o !== 1'b0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_restart got ovf %b ready %b expected 0 1", ovf_o, ready_o);
        end
    endtask

    task automatic test_restart_ignored();
        int dones = 0, strobes = 0;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, DATA_W'(i));
        step(0, 1, 0, 0);
        step(0, 1, 1, 16'd5);
        for (int i = 6; i < N + 4; i++) begin
            step(0, 0, i < N, DATA_W'(i));
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart cyc %0d got %h expected %h", i, obs, exp_vec());
            end
            if (en_wr) strobes++;
            if (done_o) dones++;
        end
        vectors++;
        if (dones != 1 || strobes != 10) begin
            miscompares++;
            $display("FAIL restart_frame dones %0d strobes_after6 %0d expected 1/10", dones, strobes);
        end
    endtask

    task automatic test_midframe_reset();
        int dones = 0;
        step(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, DATA_W'(i + 50));
        step(1, 0, 0, 0);
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL midreset_state got %h expected 0", obs);
        end
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0); if (done_o) dones++; end
        step(0, 1, 0, 0);
        step(0, 0, 1, 16'hA5A5);
        vectors++;
        if (dones != 0 || en_wr !== 1'b1 || wr_ptr !== ref_map(0) || wr_data !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL midreset_new_frame dones %0d en %b ptr %0d data %h expected 0 1 %0d a5a5",
                     dones, en_wr, wr_ptr, wr_data, ref_map(0));
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_start_valid_same();
        step(0, 0, 1, 16'h7);
        step(0, 1, 1, 16'h1234);
        vectors++;
        if (en_wr !== 1'b0 || ovf_o !== 1'b0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL start_valid got en %b ovf %b ready %b expected 0 0 1", en_wr, ovf_o, ready_o);
        end
        step(0, 0, 0, 0);
        vectors++;
        if (en_wr !== 1'b0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL start_valid_wait got en %b ready %b expected 0 1", en_wr, ready_o);
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7, DATA_W'($urandom));
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_overflow();
        test_restart_ignored();
        test_midframe_reset();
        test_start_valid_same();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/in_buffer_writer.md
IN_BUFFER_WRITER -- requirements
Module: in_buffer_writer

Interface
REQ-001 SHALL have parameter N, default 16, number of samples per FFT frame (power of two).
REQ-002 SHALL have parameter SIZE, default 4, address width, log2(N).
REQ-003 SHALL have parameter DATA_W, default 16, sample width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  arms the writer for one frame.
REQ-007 SHALL have port valid_i  input  1  din carries a sample this cycle.
REQ-008 SHALL have port din  input  DATA_W  incoming sample.
REQ-009 SHALL have port ready_o  output  1  writer accepts a sample this cycle.
REQ-010 SHALL have port en_wr  output  1  buffer write strobe.
REQ-011 SHALL have port wr_ptr  output  SIZE  buffer write address.
REQ-012 SHALL have port wr_data  output  DATA_W  buffer write data.
REQ-013 SHALL have port done_o  output  1  one-cycle frame-complete pulse, used as the FFT start_stage.
REQ-014 SHALL have port ovf_o  output  1  sticky flag: a sample was offered while not ready.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, WRITE, DONE, plus a SIZE+1-bit accepted-sample counter cnt.
REQ-016 IDLE: start_i=1 -> WAIT with cnt cleared; otherwise stay in IDLE.
REQ-017 A sample SHALL be accepted on the rising edge where ready_o=1 and valid_i=1.
REQ-018 ready_o SHALL equal (state==WAIT) or (state==WRITE and cnt<N); ready_o is decoded from registered state only.
REQ-019 On acceptance: next state is WRITE, cnt increments, and en_wr, wr_ptr=map(cnt before increment), and wr_data=din are registered, so there is one-cycle latency from acceptance to the write strobe.
REQ-020 WRITE: cnt==N -> DONE; else valid_i=1 -> WRITE (back-to-back, one write per cycle); else -> WAIT.
REQ-021 en_wr SHALL be 1 exactly in WRITE cycles; wr_ptr and wr_data SHALL hold their last values otherwise.
REQ-022 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-023 done_o SHALL be 0 in every state other than DONE.
REQ-024 Exactly N write strobes SHALL occur per frame, each address 0..N-1 written exactly once.
REQ-025 valid_i=1 while ready_o=0 (IDLE, DONE, or WRITE with cnt==N) SHALL drop the sample and set ovf_o.
REQ-026 ovf_o SHALL clear only on rst or on an accepted start_i (IDLE with start_i=1).
REQ-027 start_i outside IDLE SHALL be ignored; it does not restart or extend the frame.
REQ-028 If start_i=1 and valid_i=1 in the same IDLE cycle, the sample SHALL be dropped and ovf_o cleared, because start takes priority.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, cnt=0, en_wr=0, wr_ptr=0, wr_data=0, done_o=0, ovf_o=0.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no done_o pulse; the next frame starts at index 0.

Configuration
REQ-031 Macro BIT_REVERSE_EN defined: map(k) SHALL be the SIZE-bit bit-reversal of k, so the buffer holds natural-order input in bit-reversed order for the in-place FFT.
REQ-032 Macro BIT_REVERSE_EN undefined: map(k)=k[SIZE-1:0], giving natural order; all other behaviour is unchanged.

Verification
REQ-033 Reset, start_i pulse, then 16 back-to-back valid_i with din=0..15 -> en_wr high 16 consecutive cycles; wr_ptr=0,8,4,12,2,...,15 with BIT_REVERSE_EN (0..15 without); done_o pulses once, the cycle after the last strobe.
REQ-034 valid_i toggled 1/0 over a frame -> exactly 16 strobes, wr_data matches din order, no strobe in WAIT cycles, ovf_o=0.
REQ-035 valid_i=1 in IDLE before start, and a 17th sample offered after the 16th -> both dropped, ovf_o=1 and held; next start_i clears ovf_o.
REQ-036 start_i re-pulsed after 5 accepted samples -> ignored; frame completes after 11 more samples with a single done_o.
REQ-037 rst asserted after 7 samples -> all outputs 0 next cycle, no done_o; a new frame writes wr_ptr from map(0).
REQ-038 start_i=1 and valid_i=1 in the same IDLE cycle -> no strobe for that sample, ovf_o=0, state WAIT.
